// File: rtl/multi_channel_watchdog.sv
// N-channel heartbeat watchdog with warning, timeout, early-kick window
// and one shared fixed-width force_reset pulse toward the reset controller.
module multi_channel_watchdog #(
    parameter int NUM_CH             = 4,
    parameter int CNT_W              = 32,
    parameter int WARN_CYCLES        = 1000,
    parameter int TIMEOUT_CYCLES     = 1500,
    parameter int WINDOW_MIN         = 0,
    parameter int RESET_PULSE_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [NUM_CH-1:0] enable,
    input  logic [NUM_CH-1:0] heartbeat,
    input  logic [NUM_CH-1:0] clear,
    output logic [NUM_CH-1:0] warning,
    output logic [NUM_CH-1:0] triggered,
    output logic [NUM_CH-1:0] early_kick,
    output logic              force_reset,
    output logic              any_fault
);

    if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_ch
        $error("multi_channel_watchdog: NUM_CH out of range");
    end
    if (WINDOW_MIN < 0 || WINDOW_MIN >= WARN_CYCLES ||
        WARN_CYCLES >= TIMEOUT_CYCLES) begin : g_bad_order
        $error("multi_channel_watchdog: need WINDOW_MIN < WARN < TIMEOUT");
    end
    if (CNT_W < 32 &&
        longint'(TIMEOUT_CYCLES) >= (longint'(1) << CNT_W)) begin : g_bad_w
        $error("multi_channel_watchdog: TIMEOUT_CYCLES exceeds CNT_W");
    end
    if (RESET_PULSE_CYCLES < 1) begin : g_bad_pulse
        $error("multi_channel_watchdog: RESET_PULSE_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {
        DISABLED,
        RUNNING,
        WARNING,
        TRIGGERED
    } state_t;

    localparam bit WIN_EN = (WINDOW_MIN > 0);
    // Compare against 1 when disabled so the comparison never folds to a constant
    localparam logic [CNT_W-1:0] WIN_VAL   = CNT_W'(WIN_EN ? WINDOW_MIN : 1);
    localparam logic [CNT_W-1:0] WARN_LAST = CNT_W'(WARN_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam int               PULSE_W   = $clog2(RESET_PULSE_CYCLES + 1);
    localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(RESET_PULSE_CYCLES - 1);

    state_t           state_q [NUM_CH];
    state_t           state_d [NUM_CH];
    logic [CNT_W-1:0] cnt_q   [NUM_CH];
    logic [CNT_W-1:0] cnt_d   [NUM_CH];

    logic [NUM_CH-1:0]  warn_d;
    logic [NUM_CH-1:0]  trig_d;
    logic [NUM_CH-1:0]  early_d;
    logic [PULSE_W-1:0] pcnt_q;
    logic [PULSE_W-1:0] pcnt_d;
    logic               force_d;
    logic               rise;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            trig_d[i]  = clear[i] ? 1'b0 : triggered[i];
            early_d[i] = clear[i] ? 1'b0 : early_kick[i];
            case (state_q[i])
                DISABLED: begin
                    cnt_d[i] = '0;
                    if (enable[i]) state_d[i] = RUNNING;
                end
                RUNNING, WARNING: begin
                    if (!enable[i]) begin
                        state_d[i] = DISABLED;
                        cnt_d[i]   = '0;
                    end else if (heartbeat[i] && WIN_EN &&
                                 cnt_q[i] < WIN_VAL) begin
                        state_d[i] = TRIGGERED;
                        trig_d[i]  = 1'b1;
                        early_d[i] = 1'b1;
                    end else if (heartbeat[i]) begin
                        state_d[i] = RUNNING;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == TO_LAST) begin
                        state_d[i] = TRIGGERED;
                        trig_d[i]  = 1'b1;
                    end else if (cnt_q[i] == WARN_LAST) begin
                        state_d[i] = WARNING;
                        cnt_d[i]   = cnt_q[i] + 1'b1;
                    end else begin
                        cnt_d[i]   = cnt_q[i] + 1'b1;
                    end
                end
                TRIGGERED: begin
                    if (clear[i]) begin
                        state_d[i] = enable[i] ? RUNNING : DISABLED;
                        cnt_d[i]   = '0;
                    end else if (!enable[i]) begin
                        state_d[i] = DISABLED;
                        cnt_d[i]   = '0;
                    end
                end
                default: begin
                    state_d[i] = DISABLED;
                    cnt_d[i]   = '0;
                end
            endcase
            warn_d[i] = (state_d[i] == WARNING);
        end
    end

    // A pulse runs to completion; only a trigger seen after it ends re-arms it
    assign rise = |(trig_d & ~triggered);

    always_comb begin
        force_d = 1'b0;
        pcnt_d  = '0;
        if (force_reset && pcnt_q != '0) begin
            force_d = 1'b1;
            pcnt_d  = pcnt_q - 1'b1;
        end else if (rise) begin
            force_d = 1'b1;
            pcnt_d  = PULSE_LAST;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= DISABLED;
                cnt_q[i]   <= '0;
            end
            warning     <= '0;
            triggered   <= '0;
            early_kick  <= '0;
            force_reset <= 1'b0;
            pcnt_q      <= '0;
            any_fault   <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            warning     <= warn_d;
            triggered   <= trig_d;
            early_kick  <= early_d;
            force_reset <= force_d;
            pcnt_q      <= pcnt_d;
            any_fault   <= |(triggered | early_kick);
        end
    end

endmodule

// File: tb/tb_multi_channel_watchdog.sv
// Directed bench for multi_channel_watchdog: two channels, WARN=8,
// TIMEOUT=12, WINDOW_MIN=3, RESET_PULSE=4.
module tb_multi_channel_watchdog;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [1:0] enable = '0;
    logic [1:0] heartbeat = '0;
    logic [1:0] clear = '0;
    logic [1:0] warning;
    logic [1:0] triggered;
    logic [1:0] early_kick;
    logic       force_reset;
    logic       any_fault;

    int n_cmp = 0;
    int n_bad = 0;

    multi_channel_watchdog #(
        .NUM_CH(2),
        .CNT_W(16),
        .WARN_CYCLES(8),
        .TIMEOUT_CYCLES(12),
        .WINDOW_MIN(3),
        .RESET_PULSE_CYCLES(4)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .enable(enable),
        .heartbeat(heartbeat),
        .clear(clear),
        .warning(warning),
        .triggered(triggered),
        .early_kick(early_kick),
        .force_reset(force_reset),
        .any_fault(any_fault)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        enable = '0;
        heartbeat = '0;
        clear = '0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        logic [7:0] all;
        rstn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            enable = 2'($urandom);
            heartbeat = 2'($urandom);
            clear = 2'($urandom);
            tick();
            all = {warning, triggered, early_kick, force_reset, any_fault};
            n_cmp++;
            if (all !== 8'h00) begin
                n_bad++;
                $display("FAIL reset_hold: got %0h want 0", all);
            end
        end
        enable = '0;
        heartbeat = '0;
        clear = '0;
        rstn = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            all = {warning, triggered, early_kick, force_reset, any_fault};
            n_cmp++;
            if (all !== 8'h00) begin
                n_bad++;
                $display("FAIL reset_release: got %0h want 0", all);
            end
        end
    endtask

    task automatic test_timeout();
        enable = 2'b01;
        tick();
        for (int k = 1; k <= 17; k++) begin
            tick();
            n_cmp++;
            if (warning !== {1'b0, (k >= 8 && k < 12)}) begin
                n_bad++;
                $display("FAIL to_warning k=%0d: got %b", k, warning);
            end
            n_cmp++;
            if (triggered !== {1'b0, (k >= 12)}) begin
                n_bad++;
                $display("FAIL to_triggered k=%0d: got %b", k, triggered);
            end
            n_cmp++;
            if (force_reset !== (k >= 12 && k <= 15)) begin
                n_bad++;
                $display("FAIL to_force k=%0d: got %b", k, force_reset);
            end
            n_cmp++;
            if (any_fault !== (k >= 13)) begin
                n_bad++;
                $display("FAIL to_any_fault k=%0d: got %b", k, any_fault);
            end
        end
        clear = 2'b01;
        enable = 2'b00;
        tick();
        clear = 2'b00;
        n_cmp++;
        if (triggered !== 2'b00) begin
            n_bad++;
            $display("FAIL to_clear: got %b want 00", triggered);
        end
        tick();
        n_cmp++;
        if (any_fault !== 1'b0) begin
            n_bad++;
            $display("FAIL to_any_fault_clr: got %b want 0", any_fault);
        end
    endtask

    task automatic test_periodic();
        enable = 2'b01;
        tick();
        for (int r = 0; r < 10; r++) begin
            for (int j = 0; j < 6; j++) begin
                heartbeat = (j == 5) ? 2'b01 : 2'b00;
                tick();
                n_cmp++;
                if ((warning | triggered | early_kick) !== 2'b00) begin
                    n_bad++;
                    $display("FAIL periodic r=%0d j=%0d: got %b%b%b",
                             r, j, warning, triggered, early_kick);
                end
            end
        end
        heartbeat = 2'b00;
        for (int j = 1; j <= 11; j++) begin
            tick();
            n_cmp++;
            if (warning !== {1'b0, (j >= 8)}) begin
                n_bad++;
                $display("FAIL slow_warn j=%0d: got %b", j, warning);
            end
        end
        heartbeat = 2'b01;
        tick();
        heartbeat = 2'b00;
        n_cmp++;
        if ({warning, triggered, early_kick} !== 6'b0) begin
            n_bad++;
            $display("FAIL terminal_kick: got %b%b%b want 0",
                     warning, triggered, early_kick);
        end
        for (int j = 1; j <= 8; j++) begin
            tick();
            n_cmp++;
            if (warning !== {1'b0, (j == 8)}) begin
                n_bad++;
                $display("FAIL terminal_restart j=%0d: got %b", j, warning);
            end
        end
        idle();
    endtask

    task automatic test_early_kick();
        enable = 2'b10;
        tick();
        tick();
        heartbeat = 2'b10;
        tick();
        heartbeat = 2'b00;
        n_cmp++;
        if ({early_kick, triggered} !== 4'b1010) begin
            n_bad++;
            $display("FAIL early_flags: got %b%b want 1010",
                     early_kick, triggered);
        end
        n_cmp++;
        if (force_reset !== 1'b1) begin
            n_bad++;
            $display("FAIL early_force_rise: got %b want 1", force_reset);
        end
        for (int k = 1; k <= 4; k++) begin
            tick();
            n_cmp++;
            if (force_reset !== (k < 4)) begin
                n_bad++;
                $display("FAIL early_force k=%0d: got %b", k, force_reset);
            end
        end
        n_cmp++;
        if (any_fault !== 1'b1) begin
            n_bad++;
            $display("FAIL early_any_fault: got %b want 1", any_fault);
        end
        clear = 2'b10;
        tick();
        clear = 2'b00;
        n_cmp++;
        if ({early_kick, triggered} !== 4'b0000) begin
            n_bad++;
            $display("FAIL early_clear: got %b%b want 0000",
                     early_kick, triggered);
        end
        for (int j = 1; j <= 8; j++) begin
            tick();
            n_cmp++;
            if (warning !== {(j == 8), 1'b0}) begin
                n_bad++;
                $display("FAIL early_resume j=%0d: got %b", j, warning);
            end
            if (j == 1) begin
                n_cmp++;
                if (any_fault !== 1'b0) begin
                    n_bad++;
                    $display("FAIL early_any_fault_clr: got %b", any_fault);
                end
            end
        end
        idle();
    endtask

    task automatic test_overlap();
        enable = 2'b01;
        tick();
        tick();
        enable = 2'b11;
        tick();
        for (int k = 3; k <= 20; k++) begin
            tick();
            n_cmp++;
            if (force_reset !== (k >= 12 && k <= 15)) begin
                n_bad++;
                $display("FAIL ovl_force k=%0d: got %b", k, force_reset);
            end
            n_cmp++;
            if (triggered !== {(k >= 14), (k >= 12)}) begin
                n_bad++;
                $display("FAIL ovl_trig k=%0d: got %b", k, triggered);
            end
        end
        clear = 2'b01;
        tick();
        clear = 2'b00;
        n_cmp++;
        if (triggered !== 2'b10) begin
            n_bad++;
            $display("FAIL ovl_clear0: got %b want 10", triggered);
        end
        clear = 2'b10;
        tick();
        clear = 2'b00;
        n_cmp++;
        if (triggered !== 2'b00) begin
            n_bad++;
            $display("FAIL ovl_clear1: got %b want 00", triggered);
        end
        idle();
    endtask

    task automatic test_back_to_back();
        enable = 2'b01;
        tick();
        tick();
        tick();
        tick();
        enable = 2'b11;
        tick();
        for (int k = 5; k <= 22; k++) begin
            tick();
            n_cmp++;
            if (force_reset !== (k >= 12 && k <= 19)) begin
                n_bad++;
                $display("FAIL b2b_force k=%0d: got %b", k, force_reset);
            end
        end
        clear = 2'b11;
        enable = 2'b00;
        tick();
        idle();
    endtask

    task automatic test_disruption();
        enable = 2'b01;
        tick();
        for (int j = 1; j <= 9; j++) tick();
        n_cmp++;
        if (warning !== 2'b01) begin
            n_bad++;
            $display("FAIL dis_warn: got %b want 01", warning);
        end
        enable = 2'b00;
        tick();
        n_cmp++;
        if ({warning, triggered} !== 4'b0000) begin
            n_bad++;
            $display("FAIL dis_drop: got %b%b want 0000", warning, triggered);
        end
        enable = 2'b01;
        tick();
        for (int j = 1; j <= 12; j++) begin
            tick();
            if (j == 11) begin
                n_cmp++;
                if (triggered !== 2'b00) begin
                    n_bad++;
                    $display("FAIL dis_restart: got %b want 00", triggered);
                end
            end
        end
        n_cmp++;
        if ({force_reset, triggered} !== 3'b101) begin
            n_bad++;
            $display("FAIL dis_pulse: got %b%b want 101",
                     force_reset, triggered);
        end
        #2;
        rstn = 1'b0;
        #1;
        n_cmp++;
        if ({force_reset, triggered, warning, early_kick, any_fault} !== 8'h00) begin
            n_bad++;
            $display("FAIL dis_async_rst: got %b%b%b%b%b want 0", force_reset,
                     triggered, warning, early_kick, any_fault);
        end
        enable = 2'b00;
        tick();
        rstn = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_timeout();
        test_periodic();
        test_early_kick();
        test_overlap();
        test_back_to_back();
        test_disruption();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multi_channel_watchdog.md
Name: multi_channel_watchdog

Overview:
Parametrised N-channel successor to the single-channel watchdog. Each channel independently supervises one heartbeat source and raises warning, then timeout. An optional early-kick window detects runaway firmware that kicks too often. Any channel fault raises one shared, fixed-width force_reset pulse toward the system reset controller.

Parameters:
NUM_CH, 4, number of supervised channels (1..16)
CNT_W, 32, per-channel counter width
WARN_CYCLES, 1000, cycles without a kick before warning asserts
TIMEOUT_CYCLES, 1500, cycles without a kick before timeout
WINDOW_MIN, 0, minimum counter value for a legal kick; 0 disables window mode
RESET_PULSE_CYCLES, 16, force_reset pulse width in cycles
Legal ranges: WINDOW_MIN < WARN_CYCLES < TIMEOUT_CYCLES < 2^CNT_W; RESET_PULSE_CYCLES >= 1. These are checked at elaboration.

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
enable  in  NUM_CH  per-channel enable, level
heartbeat  in  NUM_CH  per-channel kick; every high cycle counts as one kick
clear  in  NUM_CH  per-channel fault acknowledge, single-cycle
warning  out  NUM_CH  channel is in WARNING state
triggered  out  NUM_CH  sticky timeout flag
early_kick  out  NUM_CH  sticky window-violation flag
force_reset  out  1  system reset request pulse
any_fault  out  1  registered OR of all triggered and early_kick bits

Behaviour:
- Reset: rstn low asynchronously clears all state. All outputs are 0, every counter is 0, and every channel is in DISABLED.
- Each channel has a counter and a 4-state FSM: DISABLED, RUNNING, WARNING, TRIGGERED. All outputs are registered.
- DISABLED:
  - Counter is held at 0.
  - enable=1 moves the channel to RUNNING with counter 0. Call this edge E0.
- RUNNING and WARNING, priority from highest to lowest:
  1. enable=0 -> DISABLED next edge; counter 0; warning 0. triggered and early_kick are retained.
  2. heartbeat=1 with WINDOW_MIN>0 and counter<WINDOW_MIN -> TRIGGERED; early_kick=1; triggered=1.
  3. heartbeat=1 otherwise -> counter 0; state RUNNING; warning 0 next edge.
  4. counter==TIMEOUT_CYCLES-1 -> TRIGGERED; triggered=1; warning 0.
  5. counter==WARN_CYCLES-1 -> WARNING; warning=1; counter+1.
  6. Otherwise -> counter+1.
- Timing with no kicks: warning rises at E0+WARN_CYCLES and triggered rises at E0+TIMEOUT_CYCLES.
- A kick arriving on the terminal cycle wins, so no timeout occurs.
- TRIGGERED:
  - Counter is frozen and heartbeat is ignored.
  - clear=1 clears triggered and early_kick. The channel goes to RUNNING (counter 0) if enable=1, else DISABLED.
  - enable=0 without clear -> DISABLED; flags stay set.
- clear outside TRIGGERED clears that channel's sticky flags only; the FSM is unaffected. If clear and heartbeat arrive together in TRIGGERED, clear wins.
- force_reset:
  - Rises on the same edge that any channel's triggered bit 0->1. It stays high for exactly RESET_PULSE_CYCLES cycles, driven by an internal pulse counter.
  - New triggers during an active pulse do not extend or restart it.
  - A trigger on the edge where the pulse ends starts a new pulse immediately, so the output stays high.
- any_fault updates one cycle after the flags change.
- Channels are fully independent. Simultaneous triggers on several channels produce one pulse.
- Counter arithmetic is unsigned CNT_W-bit and never wraps, because TIMEOUT bounds it.

Test Plan:
All scenarios use NUM_CH=2, WARN=8, TIMEOUT=12, WINDOW_MIN=3, RESET_PULSE=4.
1. Reset: rstn low for 3 cycles with random inputs -> all outputs 0. Deassert rstn with enable=0 -> outputs stay 0.
2. Timeout: enable[0]=1 at E0, no kicks -> warning[0] rises at E0+8; at E0+12 warning[0]=0 and triggered[0]=1; force_reset high for exactly 4 cycles; any_fault=1 at E0+13; channel 1 stays 0.
3. Periodic kicks: heartbeat[0] when counter=5, repeated 10 times -> warning, triggered and early_kick never assert. A kick at counter=11 (terminal cycle) -> no trigger; counter returns to 0.
4. Early kick: heartbeat[1] at counter=1 -> early_kick[1]=1 and triggered[1]=1 next edge; force_reset pulses 4 cycles. clear[1] -> flags 0; channel RUNNING with counter 0.
5. Overlapping faults: ch0 times out, then ch1 triggers 2 cycles later -> one force_reset pulse, still 4 cycles total; both triggered bits sticky until their own clear.
6. Mid-operation disruption: drop enable[0] while in WARNING -> warning 0 next edge, DISABLED. Separately, assert rstn low mid-pulse -> force_reset and all flags clear immediately, without waiting for a clock edge.
